// File: rtl/core_pkg.sv
// Shared core types: datapath width, register index type and the hardwired-zero index.
package core_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_rdport.sv
// Combinational register read mux with optional same-cycle writeback bypass.
module wb_regfile_rdport
  import core_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int DW        = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  reg_idx_t                     idx_i,
  input  logic [NREGS-1:0][DW-1:0]     regs_i,
  input  logic [DW-1:0]                wb_val_i,
  input  reg_idx_t                     wb_rd_i,
  input  logic                         wb_we_i,
  output logic [DW-1:0]                data_o
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [IW-1:0] sel;
  logic          in_range;
  logic          hit;

  assign sel      = idx_i[IW-1:0];
  assign in_range = int'(idx_i) < NREGS;
  assign hit      = BYPASS_EN && wb_we_i && (wb_rd_i == idx_i);

  // x0 and out-of-range indices read zero even when a writeback targets them.
  always_comb begin
    data_o = '0;
    if (idx_i != REG_ZERO && in_range) begin
      if (hit) data_o = wb_val_i;
      else     data_o = regs_i[sel];
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback-side integer register file: flop array, two bypassable read ports,
// one non-bypassed debug port and a saturating committed-write counter.
module wb_regfile
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  wb_val_i,
  input  reg_idx_t         wb_rd_i,
  input  logic             wb_we_i,
  input  reg_idx_t         rs1_idx_i,
  output logic [XLEN-1:0]  rs1_data_o,
  input  reg_idx_t         rs2_idx_i,
  output logic [XLEN-1:0]  rs2_data_o,
  input  reg_idx_t         dbg_idx_i,
  output logic [XLEN-1:0]  dbg_data_o,
  output logic [CNT_W-1:0] wr_count_o
);
  localparam int NPORTS = 2;
  localparam int IW     = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       commit;
  logic [IW-1:0]              wsel;

  assign commit = wb_we_i && (wb_rd_i != REG_ZERO) && (int'(wb_rd_i) < NREGS);
  assign wsel   = wb_rd_i[IW-1:0];

  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[wsel] = wb_val_i;
    regs_d[0] = '0;
  end

  // Counter sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (commit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wr_count_o = cnt_q;

  reg_idx_t [NPORTS-1:0]           rd_idx;
  logic     [NPORTS-1:0][XLEN-1:0] rd_data;

  assign rd_idx     = {rs2_idx_i, rs1_idx_i};
  assign rs1_data_o = rd_data[0];
  assign rs2_data_o = rd_data[1];

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    wb_regfile_rdport #(
      .NREGS     (NREGS),
      .DW        (XLEN),
      .BYPASS_EN (BYPASS_EN)
    ) u_rd (
      .idx_i    (rd_idx[p]),
      .regs_i   (regs_q),
      .wb_val_i (wb_val_i),
      .wb_rd_i  (wb_rd_i),
      .wb_we_i  (wb_we_i),
      .data_o   (rd_data[p])
    );
  end

  wb_regfile_rdport #(
    .NREGS     (NREGS),
    .DW        (XLEN),
    .BYPASS_EN (1'b0)
  ) u_dbg (
    .idx_i    (dbg_idx_i),
    .regs_i   (regs_q),
    .wb_val_i (wb_val_i),
    .wb_rd_i  (wb_rd_i),
    .wb_we_i  (wb_we_i),
    .data_o   (dbg_data_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench: three register-file variants (bypass, no bypass, 4-bit counter) share one stimulus.
module tb_wb_regfile;
  logic        clk;
  logic        rst_n;
  logic [31:0] wb_val;
  logic [4:0]  wb_rd, rs1_idx, rs2_idx, dbg_idx;
  logic        wb_we;

  logic [31:0] a_rs1, a_rs2, a_dbg, a_cnt;
  logic [31:0] b_rs1, b_rs2, b_dbg, b_cnt;
  logic [31:0] c_rs1, c_rs2, c_dbg;
  logic [3:0]  c_cnt;

  int total = 0;
  int bad   = 0;

  wb_regfile u_byp (
    .clk(clk), .rst_n(rst_n), .wb_val_i(wb_val), .wb_rd_i(wb_rd), .wb_we_i(wb_we),
    .rs1_idx_i(rs1_idx), .rs1_data_o(a_rs1), .rs2_idx_i(rs2_idx), .rs2_data_o(a_rs2),
    .dbg_idx_i(dbg_idx), .dbg_data_o(a_dbg), .wr_count_o(a_cnt));

  wb_regfile #(.BYPASS_EN(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .wb_val_i(wb_val), .wb_rd_i(wb_rd), .wb_we_i(wb_we),
    .rs1_idx_i(rs1_idx), .rs1_data_o(b_rs1), .rs2_idx_i(rs2_idx), .rs2_data_o(b_rs2),
    .dbg_idx_i(dbg_idx), .dbg_data_o(b_dbg), .wr_count_o(b_cnt));

  wb_regfile #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .rst_n(rst_n), .wb_val_i(wb_val), .wb_rd_i(wb_rd), .wb_we_i(wb_we),
    .rs1_idx_i(rs1_idx), .rs1_data_o(c_rs1), .rs2_idx_i(rs2_idx), .rs2_data_o(c_rs2),
    .dbg_idx_i(dbg_idx), .dbg_data_o(c_dbg), .wr_count_o(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wb_val = '0; wb_rd = '0; wb_we = 1'b0;
    rs1_idx = '0; rs2_idx = '0; dbg_idx = '0;
    #3;
    rs1_idx = 5'd5; dbg_idx = 5'd31;
    #1;
    chk("rst_rs1",  a_rs1, 32'h0);
    chk("rst_dbg",  a_dbg, 32'h0);
    chk("rst_cnt",  a_cnt, 32'h0);
    chk("rst_cnt4", {28'h0, c_cnt}, 32'h0);
    step();
    rst_n = 1'b1;

    // write x5, then async reset mid-cycle while x6 write is pending
    wb_we = 1'b1; wb_rd = 5'd5; wb_val = 32'hDEADBEEF;
    step();
    dbg_idx = 5'd5;
    #1;
    chk("x5_written", a_dbg, 32'hDEADBEEF);
    chk("cnt_before_rst", a_cnt, 32'd1);
    wb_rd = 5'd6; wb_val = 32'hAAAA5555;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_x5_dbg", a_dbg, 32'h0);
    chk("rst_x5_rs1", a_rs1, 32'h0);
    dbg_idx = 5'd6;
    #1;
    chk("rst_x6_dbg", a_dbg, 32'h0);
    chk("rst_mid_cnt", a_cnt, 32'h0);
    wb_we = 1'b0;
    step();
    chk("rst_x6_after_edge", a_dbg, 32'h0);
    rst_n = 1'b1;

    // basic write/read
    wb_we = 1'b1; wb_rd = 5'd3; wb_val = 32'h12345678;
    step();
    wb_we = 1'b0; rs1_idx = 5'd3; dbg_idx = 5'd3;
    #1;
    chk("basic_rs1", a_rs1, 32'h12345678);
    chk("basic_dbg", a_dbg, 32'h12345678);
    chk("basic_cnt", a_cnt, 32'd1);
    chk("basic_nb_rs1", b_rs1, 32'h12345678);
    step();
    chk("basic_rs1_hold", a_rs1, 32'h12345678);

    // x0 protection
    wb_we = 1'b1; wb_rd = 5'd0; wb_val = 32'hFFFFFFFF; rs1_idx = 5'd0; rs2_idx = 5'd0;
    #1;
    chk("x0_rs1_same", a_rs1, 32'h0);
    chk("x0_rs2_same", a_rs2, 32'h0);
    step();
    wb_we = 1'b0;
    #1;
    chk("x0_rs1_after", a_rs1, 32'h0);
    chk("x0_rs2_after", a_rs2, 32'h0);
    chk("x0_cnt", a_cnt, 32'd1);

    // bypass vs no bypass
    wb_we = 1'b1; wb_rd = 5'd7; wb_val = 32'h11;
    step();
    wb_val = 32'h22; rs1_idx = 5'd7; rs2_idx = 5'd7; dbg_idx = 5'd7;
    #1;
    chk("byp_rs1", a_rs1, 32'h22);
    chk("byp_rs2", a_rs2, 32'h22);
    chk("byp_dbg", a_dbg, 32'h11);
    chk("nobyp_rs1", b_rs1, 32'h11);
    chk("nobyp_rs2", b_rs2, 32'h11);
    step();
    wb_we = 1'b0;
    #1;
    chk("byp_dbg_after", a_dbg, 32'h22);
    chk("nobyp_rs1_after", b_rs1, 32'h22);
    chk("nobyp_rs2_after", b_rs2, 32'h22);
    chk("byp_cnt", a_cnt, 32'd3);

    // back-to-back writes and 4-bit counter saturation
    rs1_idx = 5'd9;
    wb_we = 1'b1; wb_rd = 5'd9;
    for (int i = 1; i <= 3; i++) begin
      wb_val = 32'(i);
      step();
    end
    wb_we = 1'b0;
    #1;
    chk("b2b_x9", c_rs1, 32'd3);
    chk("b2b_cnt4", {28'h0, c_cnt}, 32'd6);
    wb_we = 1'b1; wb_rd = 5'd10;
    for (int i = 0; i < 20; i++) begin
      wb_val = 32'(100 + i);
      step();
      if (i == 8) chk("cnt4_reach15", {28'h0, c_cnt}, 32'd15);
    end
    wb_we = 1'b0;
    dbg_idx = 5'd10;
    #1;
    chk("cnt4_sat", {28'h0, c_cnt}, 32'd15);
    chk("cnt32_total", a_cnt, 32'd26);
    chk("x10_last", a_dbg, 32'd119);
    step();
    chk("cnt4_sat_hold", {28'h0, c_cnt}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Integer register file that consumes the MEM/WB pipeline register outputs: writeback value, destination index and write enable.
- Provides two combinational read ports to the decode stage, with optional same-cycle write-to-read bypass.
- Also provides one combinational debug read port and a saturating count of committed writes.
- Sits at the writeback end of the pipeline; it is the consumer of the writeback interface.

Parameters:
- XLEN, 32, data width of each register and of the writeback value
- NREGS, 32, number of architectural registers (index width is clog2(NREGS), 5 by default)
- BYPASS_EN, 1, 1 = a write in the current cycle is visible on the read ports in the same cycle; 0 = it is visible only after the clock edge
- CNT_W, 32, width of the committed-write counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_val_i  input  XLEN  writeback value from MEM/WB
- wb_rd_i  input  5  destination register index from MEM/WB
- wb_we_i  input  1  register write enable from MEM/WB
- rs1_idx_i  input  5  read port 1 index
- rs1_data_o  output  XLEN  read port 1 data
- rs2_idx_i  input  5  read port 2 index
- rs2_data_o  output  XLEN  read port 2 data
- dbg_idx_i  input  5  debug read index
- dbg_data_o  output  XLEN  debug read data (never bypassed)
- wr_count_o  output  CNT_W  number of committed writes, saturating

Behaviour:
- Interface (decided): one clock, clk; reset rst_n, asynchronous and active-low.
- Reset: while rst_n = 0, all registers x1..x(NREGS-1) = 0 and wr_count_o = 0. Takes effect immediately, independent of clk.
- Reset during a pending write: the write is discarded.
- Reset release: the first write commits on the first rising edge at which rst_n = 1.
- Commit condition: a write commits on a rising clk edge when wb_we_i = 1 and wb_rd_i != 0. The register at index wb_rd_i takes wb_val_i.
- Latency: one cycle from MEM/WB output to register-array update.
- x0 is hardwired to zero:
  - writes to index 0 are dropped;
  - reads of index 0 return 0 on every port, regardless of bypass;
  - writes to index 0 do not increment wr_count_o.
- Indices >= NREGS (only possible when NREGS < 32): writes are ignored and reads return 0.
- Read ports (purely combinational, zero latency):
  - If idx = 0, data = 0.
  - Else if BYPASS_EN = 1 and wb_we_i = 1 and wb_rd_i = idx, data = wb_val_i.
  - Otherwise data = stored register.
- rs1 and rs2 may address the same register; both ports return identical data.
- Both read ports may match the bypass at the same time.
- Debug port: always returns the stored value (or 0 for index 0). It never shows in-flight writeback data.
- wr_count_o:
  - increments by 1 on each committed write;
  - holds at all-ones once saturated (no wrap-around);
  - clears only on reset.
- Consecutive writes to the same index on back-to-back cycles: the last one wins; each one counts.
- No handshake and no backpressure: every qualifying writeback is committed unconditionally.
- Storage is flops (not an inferred RAM), so the asynchronous reset can clear the array.

Decomposition:
- Shared package (core_pkg):
  - XLEN constant;
  - REG_IDX_W = 5;
  - typedef reg_idx_t (logic [4:0]);
  - typedef xword_t (logic [XLEN-1:0]);
  - localparam REG_ZERO = 5'd0.
- One sub-module is natural: wb_regfile_rdport. It is a combinational read mux plus bypass compare, instantiated twice (rs1, rs2) with BYPASS_EN passed through.
- The debug port uses the same sub-module with bypass forced off.

Test Plan:
- Reset during traffic:
  - Stimulus: write x5 = 0xDEADBEEF, then pulse rst_n low mid-cycle while wb_we_i = 1 targets x6.
  - Required response: x5 and x6 read 0 immediately, with no clock edge needed; wr_count_o = 0.
- Basic write/read:
  - Stimulus: wb_we_i = 1, wb_rd_i = 3, wb_val_i = 0x12345678, then idle.
  - Required response: rs1_idx = 3 reads 0x12345678 from the next cycle on; dbg_idx = 3 also returns 0x12345678; wr_count_o = 1.
- x0 protection:
  - Stimulus: write x0 = 0xFFFFFFFF with rs1_idx = rs2_idx = 0 in the same cycle.
  - Required response: both ports return 0 in that cycle and afterwards; wr_count_o is unchanged.
- Bypass with BYPASS_EN = 1:
  - Stimulus: x7 holds 0x11; drive a write of x7 = 0x22 with rs1_idx = rs2_idx = 7.
  - Required response: both ports show 0x22 in the same cycle; dbg_data_o shows 0x11 until the edge, then 0x22.
- No bypass with BYPASS_EN = 0:
  - Stimulus: the same stimulus as the bypass scenario.
  - Required response: ports show 0x11 in the write cycle and 0x22 after the edge.
- Back-to-back writes and counter saturation:
  - Stimulus: with CNT_W = 4, write x9 = 1, 2, 3 on consecutive cycles, then 20 more writes.
  - Required response: x9 reads 3 after the third edge; wr_count_o holds at 15.
